ofdm_bit_deinterleaver: RTL and testbench

//  Sits directly after demod in the receive chain. Takes one QPSK symbol per beat (2 bits) for the 48 data subcarriers of one OFDM symbol.

---
 rtl/ofdm_rx_pkg.sv | 41 ++++
 rtl/deint_addr_gen.sv | 59 +++++
 rtl/ofdm_bit_deinterleaver.sv | 241 ++++++++++++++++++++++++
 tb/tb_ofdm_bit_deinterleaver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_rx_pkg
// Shared constants and types for the OFDM receive-side bit deinterleaver.
//   N_SD         data subcarriers (beats) per OFDM symbol / per bank
//   N_CBPS_QPSK  coded bits per OFDM symbol with QPSK (bank depth in bits)
//   N_CBPS_BPSK  coded bits per OFDM symbol with BPSK
//   N_COL        interleaver columns
//   N_ROW        interleaver rows per bit of N_BPSC
// Types:
//   cnt_t       beat / pair counter
//   kaddr_t     bit address inside a bank (original bit index k)
//   rd_state_t  readout FSM state
// ---------------------------------------------------------------------------
package ofdm_rx_pkg;

  localparam int N_SD        = 48;
  localparam int N_CBPS_QPSK = 96;
  localparam int N_CBPS_BPSK = 48;
  localparam int N_COL       = 16;
  localparam int N_ROW       = 3;

  // k = N_COL*r + c is formed by concatenating {r, c}; N_COL is a power of 2.
  localparam int COL_SHIFT = $clog2(N_COL);
  localparam int ROW_W     = 3;
  localparam int K_W       = $clog2(N_CBPS_QPSK);
  localparam int CNT_W     = $clog2(N_SD);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [K_W-1:0]   kaddr_t;

  typedef enum logic {
    IDLE,
    STREAM
  } rd_state_t;

  // Index of the final output pair of a bank, depending on its modulation.
  function automatic cnt_t last_pair(input logic bpsk);
    return bpsk ? cnt_t'(N_CBPS_BPSK / 2 - 1) : cnt_t'(N_CBPS_QPSK / 2 - 1);
  endfunction

endpackage

// File: rtl/deint_addr_gen.sv
// ---------------------------------------------------------------------------
// deint_addr_gen
// Running (row, column) counters that map the received coded-bit index j to
// the original bit index k = N_COL*(j mod rows) + j/rows, without any
// multiply or divide on j.
//   QPSK: two bits per beat (j = 2m, 2m+1), rows = 6. The even bit always
//         lands on an even row, so the odd bit is the next row, same column.
//   BPSK: one bit per beat (j = m), rows = 3.
// Ports:
//   i_clk     clock, rising edge
//   i_srst    synchronous active-high reset
//   i_clr     restart at j = 0 (flush or bank wrap); wins over i_adv
//   i_adv     a beat was accepted, step to the next beat
//   i_bpsk    modulation of the bank being written (selects step and wrap)
//   o_k_even  k for bit j = 2m (QPSK) or j = m (BPSK)
//   o_k_odd   k for bit j = 2m+1 (QPSK only)
// ---------------------------------------------------------------------------
module deint_addr_gen
  import ofdm_rx_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_srst,
  input  logic           i_clr,
  input  logic           i_adv,
  input  logic           i_bpsk,
  output logic [K_W-1:0] o_k_even,
  output logic [K_W-1:0] o_k_odd
);

  logic [ROW_W-1:0]     r_row;
  logic [COL_SHIFT-1:0] r_col;

  logic [ROW_W-1:0] w_row_step;
  logic [ROW_W-1:0] w_row_wrap;
  logic [ROW_W-1:0] w_row_odd;

  // QPSK walks rows 0,2,4 for the even bit; BPSK walks rows 0,1,2.
  assign w_row_step = i_bpsk ? ROW_W'(1) : ROW_W'(2);
  assign w_row_wrap = i_bpsk ? ROW_W'(N_ROW - 1) : ROW_W'(2 * N_ROW - 2);
  assign w_row_odd  = r_row + ROW_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_srst || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (r_row == w_row_wrap) begin
        r_row <= '0;
        r_col <= r_col + COL_SHIFT'(1);
      end else begin
        r_row <= r_row + w_row_step;
      end
    end
  end

  assign o_k_even = {r_row, r_col};
  assign o_k_odd  = {w_row_odd, r_col};

endmodule

// File: rtl/ofdm_bit_deinterleaver.sv
// ---------------------------------------------------------------------------
// ofdm_bit_deinterleaver
// Undoes the 802.11a block interleaver (N_CBPS = 96, s = 1) on the output of
// the QPSK demod, one symbol (2 coded bits) per beat, 48 beats per OFDM
// symbol. Two ping-pong banks let the capture of symbol n+1 overlap the
// readout of symbol n. Readout produces deinterleaved coded-bit pairs for the
// Viterbi stage with a valid/ready handshake.
//
// Build option: define OFDM_DEINT_BPSK_EN to add the bpsk_mode port. The mode
// is sampled at the first beat of each bank; a BPSK bank stores one bit per
// beat (in_sym[0]) and reads out 24 pairs.
//
// Ports:
//   CLK        clock, rising edge
//   s_RST      synchronous active-high reset
//   flush      new-packet clear, priority over in_valid
//   in_valid   demod beat valid
//   in_sym     bit0 = coded bit j=2m, bit1 = j=2m+1
//   bpsk_mode  (OFDM_DEINT_BPSK_EN only) modulation of the bank being started
//   in_ready   the current write bank is free
//   out_valid  out_bits valid
//   out_bits   bit0 = k=2n, bit1 = k=2n+1
//   out_ready  downstream accept
//   out_last   final pair of an OFDM symbol
//   overflow   sticky: a beat was offered while in_ready was low
// ---------------------------------------------------------------------------
module ofdm_bit_deinterleaver
  import ofdm_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       s_RST,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [1:0] in_sym,
`ifdef OFDM_DEINT_BPSK_EN
  input  logic       bpsk_mode,
`endif
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_bits,
  input  logic       out_ready,
  output logic       out_last,
  output logic       overflow
);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [N_CBPS_QPSK-1:0] r_bank [2];
  logic [1:0]             r_bank_full;
  logic [1:0]             r_bank_bpsk;

  logic      r_wr_bank;
  cnt_t      r_wr_cnt;
  logic      r_overflow;

  rd_state_t r_state;
  logic      r_rd_bank;
  cnt_t      r_rd_cnt;
  logic      r_out_valid;
  logic [1:0] r_out_bits;
  logic      r_out_last;

  // ------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------
  logic       w_bpsk_in;
  logic       w_wr_bpsk;
  logic       w_accept;
  logic       w_drop;
  logic       w_last_beat;
  logic       w_rd_done;
  logic       w_oth_bank;
  logic [1:0] w_set_full;
  logic [1:0] w_clr_full;
  logic [1:0] w_avail;
  kaddr_t     w_k_even;
  kaddr_t     w_k_odd;
  cnt_t       w_rd_next;
  cnt_t       w_rd_last;
  logic [1:0] w_pair_next;

`ifdef OFDM_DEINT_BPSK_EN
  assign w_bpsk_in = bpsk_mode;
`else
  assign w_bpsk_in = 1'b0;
`endif

  // The live mode applies on the first beat of a bank; afterwards the value
  // captured on that beat governs the rest of the bank.
  assign w_wr_bpsk   = (r_wr_cnt == '0) ? w_bpsk_in : r_bank_bpsk[r_wr_bank];

  assign in_ready    = !r_bank_full[r_wr_bank];
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_drop      = in_valid && !in_ready;
  assign w_last_beat = w_accept && (r_wr_cnt == cnt_t'(N_SD - 1));
  assign w_rd_done   = r_out_valid && out_ready && r_out_last;
  assign w_oth_bank  = ~r_rd_bank;

  // Per-bank flag events. A bank counts as available to the reader on the
  // very edge its last beat is written, which gives 1-cycle output latency.
  // Pair 0 (k = 0, 1) always comes from beats 0 and 3, so it is already in
  // storage by that edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank_ctl
      assign w_set_full[gi] = w_last_beat && (r_wr_bank == 1'(gi));
      assign w_clr_full[gi] = w_rd_done   && (r_rd_bank == 1'(gi));
      assign w_avail[gi]    = r_bank_full[gi] || w_set_full[gi];
    end
  endgenerate

  assign w_rd_next   = r_rd_cnt + cnt_t'(1);
  assign w_rd_last   = last_pair(r_bank_bpsk[r_rd_bank]);
  assign w_pair_next = r_bank[r_rd_bank][{w_rd_next, 1'b0} +: 2];

  // ------------------------------------------------------------------
  // Write address generation
  // ------------------------------------------------------------------
  deint_addr_gen u_addr_gen (
    .i_clk    (CLK),
    .i_srst   (s_RST),
    .i_clr    (flush || w_last_beat),
    .i_adv    (w_accept),
    .i_bpsk   (w_wr_bpsk),
    .o_k_even (w_k_even),
    .o_k_odd  (w_k_odd)
  );

  // ------------------------------------------------------------------
  // Bit storage. Never cleared: a bank is only read after every bit the
  // reader will touch has been rewritten, so stale contents cannot escape.
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_bank[r_wr_bank][w_k_even] <= in_sym[0];
      if (!w_wr_bpsk) begin
        r_bank[r_wr_bank][w_k_odd] <= in_sym[1];
      end
    end
  end

  // ------------------------------------------------------------------
  // Bank full flags. Writer only sets the bank it fills, reader only clears
  // the bank it drains; these are never the same bank, so both can happen
  // on one edge.
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (s_RST || flush) begin
      r_bank_full <= '0;
    end else begin
      r_bank_full <= (r_bank_full | w_set_full) & ~w_clr_full;
    end
  end

  // ------------------------------------------------------------------
  // Write side: beat counter, bank select, per-bank mode, overflow
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (s_RST || flush) begin
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_bank_bpsk <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_wr_cnt == '0) begin
          r_bank_bpsk[r_wr_bank] <= w_bpsk_in;
        end
        if (w_last_beat) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + cnt_t'(1);
        end
      end
      // Dropped beats leave the write counters untouched.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Readout FSM with registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (s_RST || flush) begin
      r_state     <= IDLE;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_avail[r_rd_bank]) begin
            r_state     <= STREAM;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b1;
            r_out_bits  <= r_bank[r_rd_bank][1:0];
            r_out_last  <= 1'b0;
          end
        end
        STREAM: begin
          if (r_out_valid && out_ready) begin
            if (r_out_last) begin
              r_rd_bank <= w_oth_bank;
              r_rd_cnt  <= '0;
              if (w_avail[w_oth_bank]) begin
                // Back-to-back: start the other bank without a bubble.
                r_out_bits <= r_bank[w_oth_bank][1:0];
                r_out_last <= 1'b0;
              end else begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_out_bits  <= '0;
                r_out_last  <= 1'b0;
              end
            end else begin
              r_rd_cnt   <= w_rd_next;
              r_out_bits <= w_pair_next;
              r_out_last <= (w_rd_next == w_rd_last);
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_bits  = r_out_bits;
  assign out_last  = r_out_last;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ofdm_bit_deinterleaver.sv
// ---------------------------------------------------------------------------
// tb_ofdm_bit_deinterleaver
// Scoreboard bench: each kept OFDM symbol pushes its 48 expected output pairs
// (computed from k = 16*(j mod 6) + j/6) into a queue; a monitor pops and
// compares on every output handshake and checks that stalled outputs hold.
// ---------------------------------------------------------------------------
module tb_ofdm_bit_deinterleaver;

  logic       CLK;
  logic       s_RST;
  logic       flush;
  logic       in_valid;
  logic [1:0] in_sym;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_bits;
  logic       out_ready;
  logic       out_last;
  logic       overflow;
`ifdef OFDM_DEINT_BPSK_EN
  logic       bpsk_mode;
`endif

  int         checks = 0;
  int         errors = 0;
  int         pops   = 0;
  int         rdy_mode = 1;
  logic [2:0] exp_q [$];
  logic [1:0] sym_buf [48];

  ofdm_bit_deinterleaver dut (
    .CLK       (CLK),
    .s_RST     (s_RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
`ifdef OFDM_DEINT_BPSK_EN
    .bpsk_mode (bpsk_mode),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bits  (out_bits),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Golden permutation of the contents of sym_buf (QPSK).
  task automatic push_expected();
    logic [95:0] coded;
    logic [95:0] deint;
    for (int m = 0; m < 48; m++) begin
      coded[2*m]   = sym_buf[m][0];
      coded[2*m+1] = sym_buf[m][1];
    end
    for (int j = 0; j < 96; j++) begin
      deint[16*(j%6) + j/6] = coded[j];
    end
    for (int n = 0; n < 48; n++) begin
      exp_q.push_back({(n == 47), deint[2*n+1], deint[2*n]});
    end
  endtask

  task automatic fill_zero();
    for (int m = 0; m < 48; m++) sym_buf[m] = 2'b00;
  endtask

  task automatic fill_random();
    for (int m = 0; m < 48; m++) sym_buf[m] = 2'($urandom);
  endtask

  task automatic fill_counting();
    for (int m = 0; m < 48; m++) sym_buf[m] = 2'(m);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat's edge.
  task automatic send_beat(input logic [1:0] s, input bit wait_rdy);
    int guard = 0;
    if (wait_rdy) begin
      while (!in_ready && guard < 2000) begin
        in_valid = 1'b0;
        @(posedge CLK); #1;
        guard++;
      end
      if (guard >= 2000) check_eq("beat_wait_timeout", in_ready, 1);
    end
    in_valid = 1'b1;
    in_sym   = s;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    in_sym   = 2'b00;
  endtask

  task automatic send_symbol(input bit keep, input bit wait_rdy);
    if (keep) push_expected();
    for (int m = 0; m < 48; m++) send_beat(sym_buf[m], wait_rdy);
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge CLK); #1;
      cyc++;
    end
    repeat (3) begin @(posedge CLK); #1; end
    check_eq({tag, "_drain"}, exp_q.size(), 0);
    check_eq({tag, "_idle"}, out_valid, 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    flush = 1'b0;
  endtask

  // out_ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: sampled on the falling edge
  initial begin : monitor
    logic       held;
    logic [2:0] held_val;
    logic [2:0] exp_v;
    held     = 1'b0;
    held_val = '0;
    forever begin
      @(negedge CLK);
      if (s_RST || flush) begin
        held = 1'b0;
      end else begin
        if (held) check_eq("hold_stable", {out_valid, out_last, out_bits}, {1'b1, held_val});
        if (out_valid && out_ready) begin
          if (exp_q.size() > 0) exp_v = exp_q.pop_front();
          else exp_v = 3'bxxx;
          check_eq("pair", {out_last, out_bits}, exp_v);
          pops++;
          held = 1'b0;
        end else begin
          held     = out_valid;
          held_val = {out_last, out_bits};
        end
      end
    end
  end

  initial begin : main
    int base;
    int cyc;
    s_RST    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_sym   = 2'b00;
`ifdef OFDM_DEINT_BPSK_EN
    bpsk_mode = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    s_RST = 1'b0;

    // Reset state
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_bits", out_bits, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_overflow", overflow, 0);

    // 1: one-hot j=1 -> only pair 8 = 2'b01
    rdy_mode = 1;
    fill_zero();
    sym_buf[0] = 2'b10;
    send_symbol(1, 1);
    drain("t1");

    // 2: one-hot j=6 -> pair 0 = 2'b10, latency of one cycle after beat 47
    fill_zero();
    sym_buf[3] = 2'b01;
    push_expected();
    for (int m = 0; m < 47; m++) send_beat(sym_buf[m], 1);
    check_eq("t2_valid_before_last", out_valid, 0);
    send_beat(sym_buf[47], 1);
    check_eq("t2_valid_after_last", out_valid, 1);
    check_eq("t2_pair0", out_bits, 2'b10);
    drain("t2");

    // 3: three symbols back-to-back with out_ready low
    rdy_mode = 0;
    @(posedge CLK); #1;
    for (int s = 0; s < 3; s++) begin
      fill_random();
      if (s < 2) push_expected();
      for (int m = 0; m < 48; m++) begin
        if (s == 1 && m == 47) check_eq("t3_ready_beat95", in_ready, 1);
        if (s == 2 && m == 0)  check_eq("t3_ready_beat96", in_ready, 0);
        send_beat(sym_buf[m], 0);
      end
    end
    check_eq("t3_overflow", overflow, 1);
    rdy_mode = 1;
    drain("t3");
    check_eq("t3_overflow_sticky", overflow, 1);
    do_flush();
    check_eq("t3_flush_overflow", overflow, 0);

    // 4: flush after 20 beats, then a counting pattern
    fill_random();
    for (int m = 0; m < 20; m++) send_beat(sym_buf[m], 1);
    do_flush();
    check_eq("t4_flush_in_ready", in_ready, 1);
    check_eq("t4_flush_out_valid", out_valid, 0);
    fill_counting();
    send_symbol(1, 1);
    drain("t4");

    // 5: random out_ready, three symbols with a well-behaved source
    rdy_mode = 2;
    for (int s = 0; s < 3; s++) begin
      fill_random();
      send_symbol(1, 1);
    end
    rdy_mode = 1;
    drain("t5");
    check_eq("t5_no_overflow", overflow, 0);

    // 6: reset while streaming pair n=10
    base = pops;
    fill_random();
    send_symbol(1, 1);
    cyc = 0;
    while (pops < base + 10 && cyc < 200) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check_eq("t6_reached_n10", pops - base, 10);
    s_RST = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    s_RST = 1'b0;
    check_eq("t6_rst_out_valid", out_valid, 0);
    check_eq("t6_rst_out_bits", out_bits, 0);
    check_eq("t6_rst_out_last", out_last, 0);
    check_eq("t6_rst_in_ready", in_ready, 1);
    check_eq("t6_rst_overflow", overflow, 0);
    fill_random();
    send_symbol(1, 1);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
